// File: rtl/game_pkg.sv
// Shared constants and enums for the two-player shooter motion logic.
package game_pkg;

    localparam int STEP_X   = 6;
    localparam int V        = 20;
    localparam int GRAV     = 5;
    localparam int MAX_J    = 80;
    localparam int LIMIT_X  = 480;
    localparam int INIT_X   = 120;
    localparam int COOLDOWN = 8;

    typedef enum logic [1:0] {
        POSE_STAND  = 2'd0,
        POSE_SQUAT  = 2'd1,
        POSE_SHIELD = 2'd2
    } pose_t;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        JUMP   = 2'd1,
        SQUAT  = 2'd2,
        SHIELD = 2'd3
    } motion_state_t;

endpackage

// File: rtl/jump_integrator.sv
// Jump height / vertical velocity integrator; all signed arithmetic lives here.
// A launch adds V to the current height and reloads the velocity.
module jump_integrator #(
    parameter int V     = game_pkg::V,
    parameter int GRAV  = game_pkg::GRAV,
    parameter int MAX_J = game_pkg::MAX_J
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clear,
    input  logic       i_launch,
    input  logic       i_step,
    output logic [6:0] o_h,
    output logic       o_landed
);

    localparam logic signed [8:0] V_S    = 9'(V);
    localparam logic signed [8:0] GRAV_S = 9'(GRAV);
    localparam logic signed [8:0] MAX_S  = 9'(MAX_J);

    logic [6:0]        h_q, h_d;
    logic signed [8:0] vel_q, vel_d;
    logic signed [8:0] h_sum;

    // The launching tick already applies the first rise, so velocity leaves
    // the launch already reduced by one gravity step.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        h_sum    = $signed({2'b00, h_q}) + (i_launch ? V_S : vel_q);
        h_d      = h_q;
        vel_d    = vel_q;
        o_landed = 1'b0;
        if (i_launch) begin
            vel_d = V_S - GRAV_S;
            h_d   = (h_sum > MAX_S) ? 7'(MAX_J) : 7'(h_sum);
        end else if (i_step) begin
            vel_d = vel_q - GRAV_S;
            if (h_sum <= 9'sd0) begin
                h_d      = '0;
                vel_d    = '0;
                o_landed = 1'b1;
            end else if (h_sum > MAX_S) begin
                h_d = 7'(MAX_J);
            end else begin
                h_d = 7'(h_sum);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!i_rst_n) begin
            h_q   <= '0;
            vel_q <= '0;
        end else if (i_clear) begin
            h_q   <= '0;
            vel_q <= '0;
        end else begin
            h_q   <= h_d;
            vel_q <= vel_d;
        end
    end

    assign o_h = h_q;

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-player motion/action sequencer advancing once per frame tick.
// Optional build macro PLAYER_DOUBLE_JUMP_EN enables one extra mid-air jump.
module player_motion_ctrl #(
    parameter int STEP_X   = game_pkg::STEP_X,
    parameter int V        = game_pkg::V,
    parameter int GRAV     = game_pkg::GRAV,
    parameter int MAX_J    = game_pkg::MAX_J,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = game_pkg::LIMIT_X,
    parameter int INIT_X   = game_pkg::INIT_X,
    parameter int COOLDOWN = game_pkg::COOLDOWN
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_frame_tick,
    input  logic        i_active,
    input  logic        i_left,
    input  logic        i_right,
    input  logic        i_jump,
    input  logic        i_squat,
    input  logic        i_shield,
    input  logic        i_fire,
    output logic [11:0] o_x,
    output logic [6:0]  o_h,
    output logic [1:0]  o_pose,
    output logic        o_airborne,
    output logic        o_fire
);

    localparam int          CW       = $clog2(COOLDOWN + 1);
    localparam logic [12:0] LEFT_LIM = 13'(X_MIN + STEP_X);

    game_pkg::motion_state_t state_q, state_d;
    logic [11:0]   x_q, x_d;
    logic [CW-1:0] cool_q, cool_d, cool_eff;
    logic          fire_d, fire_q;
    logic          in_jump, step, launch, boost, landed, mobile;

    assign in_jump = (state_q == game_pkg::JUMP);
    assign step    = i_frame_tick && in_jump;
    assign launch  = (i_frame_tick && !in_jump && i_jump) || boost;

`ifdef PLAYER_DOUBLE_JUMP_EN
    logic jump_prev_q, air_used_q;

    assign boost = step && i_jump && !jump_prev_q && !air_used_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            jump_prev_q <= 1'b0;
            air_used_q  <= 1'b0;
        end else if (!i_active) begin
            jump_prev_q <= 1'b0;
            air_used_q  <= 1'b0;
        end else if (i_frame_tick) begin
            jump_prev_q <= i_jump;
            air_used_q  <= boost || (air_used_q && state_d == game_pkg::JUMP);
        end
    end
`else
    assign boost = 1'b0;
`endif

    jump_integrator #(
        .V     (V),
        .GRAV  (GRAV),
        .MAX_J (MAX_J)
    ) u_jump (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (!i_active),
        .i_launch (launch),
        .i_step   (step),
        .o_h      (o_h),
        .o_landed (landed)
    );

    // Movement and firing are gated by the pose the player holds after the tick.
    assign mobile   = (state_d == game_pkg::GROUND) || (state_d == game_pkg::JUMP);
    assign cool_eff = (cool_q != '0) ? cool_q - 1'b1 : '0;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        cool_d  = cool_q;
        fire_d  = 1'b0;
        if (i_frame_tick) begin
            if (in_jump) begin
                if (landed) state_d = game_pkg::GROUND;
            end else if (i_jump) begin
                state_d = game_pkg::JUMP;
            end else if (i_squat) begin
                state_d = game_pkg::SQUAT;
            end else if (i_shield) begin
                state_d = game_pkg::SHIELD;
            end else begin
                state_d = game_pkg::GROUND;
            end

            if (mobile && i_left && !i_right) begin
                x_d = ({1'b0, x_q} < LEFT_LIM) ? 12'(X_MIN) : x_q - 12'(STEP_X);
            end else if (mobile && i_right && !i_left) begin
                x_d = ({1'b0, x_q} + 13'(STEP_X) > 13'(X_MAX)) ? 12'(X_MAX)
                                                              : x_q + 12'(STEP_X);
            end

            fire_d = i_fire && mobile && (cool_eff == '0);
            cool_d = fire_d ? CW'(COOLDOWN) : cool_eff;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= game_pkg::GROUND;
            x_q     <= 12'(INIT_X);
            cool_q  <= '0;
            fire_q  <= 1'b0;
        end else if (!i_active) begin
            state_q <= game_pkg::GROUND;
            x_q     <= 12'(INIT_X);
            cool_q  <= '0;
            fire_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cool_q  <= cool_d;
            fire_q  <= fire_d;
        end
    end

    always_comb begin
        case (state_q)
            game_pkg::SQUAT:  o_pose = game_pkg::POSE_SQUAT;
            game_pkg::SHIELD: o_pose = game_pkg::POSE_SHIELD;
            default:          o_pose = game_pkg::POSE_STAND;
        endcase
    end

    assign o_x        = x_q;
    assign o_airborne = in_jump;
    assign o_fire     = fire_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Self-checking bench for player_motion_ctrl: directed scenarios plus
// randomized stimulus compared against a tick-level behavioural model.
module tb_player_motion_ctrl;

    localparam int P_STEP = 6, P_V = 20, P_GRAV = 5, P_MAXJ = 80;
    localparam int P_XMIN = 0, P_XMAX = 480, P_INITX = 120, P_COOL = 8;
`ifdef PLAYER_DOUBLE_JUMP_EN
    localparam bit DJ = 1'b1;
`else
    localparam bit DJ = 1'b0;
`endif
    localparam int S_GND = 0, S_JMP = 1, S_SQ = 2, S_SH = 3;

    logic        i_clk = 1'b0, i_rst_n = 1'b0, i_frame_tick = 1'b0, i_active = 1'b0;
    logic        i_left = 1'b0, i_right = 1'b0, i_jump = 1'b0;
    logic        i_squat = 1'b0, i_shield = 1'b0, i_fire = 1'b0;
    logic [11:0] o_x;
    logic [6:0]  o_h;
    logic [1:0]  o_pose;
    logic        o_airborne, o_fire;

    int n_tests = 0, n_fail = 0;

    // Reference model state
    int m_st, m_x, m_h, m_vel, m_cool, m_fire, m_prevj, m_air_used;

    player_motion_ctrl dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_frame_tick (i_frame_tick),
        .i_active     (i_active),
        .i_left       (i_left),
        .i_right      (i_right),
        .i_jump       (i_jump),
        .i_squat      (i_squat),
        .i_shield     (i_shield),
        .i_fire       (i_fire),
        .o_x          (o_x),
        .o_h          (o_h),
        .o_pose       (o_pose),
        .o_airborne   (o_airborne),
        .o_fire       (o_fire)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = S_GND; m_x = P_INITX; m_h = 0; m_vel = 0;
        m_cool = 0; m_fire = 0; m_prevj = 0; m_air_used = 0;
    endtask

    // One accepted frame tick, straight from the behavioural rules.
    task automatic model_tick(input bit l, r, j, sq, sh, f);
        int nst, hn, eff;
        bit mobile;
        nst = m_st;
        if (m_st == S_JMP) begin
            if (DJ && j && !m_prevj && !m_air_used) begin
                m_h = (m_h + P_V > P_MAXJ) ? P_MAXJ : m_h + P_V;
                m_vel = P_V - P_GRAV;
                m_air_used = 1;
            end else begin
                hn = m_h + m_vel;
                m_vel = m_vel - P_GRAV;
                if (hn <= 0) begin
                    m_h = 0; m_vel = 0; nst = S_GND; m_air_used = 0;
                end else begin
                    m_h = (hn > P_MAXJ) ? P_MAXJ : hn;
                end
            end
        end else if (j) begin
            nst = S_JMP; m_h = P_V; m_vel = P_V - P_GRAV;
        end else if (sq) nst = S_SQ;
        else if (sh) nst = S_SH;
        else nst = S_GND;
        m_st = nst;
        mobile = (m_st == S_GND) || (m_st == S_JMP);
        if (mobile && l && !r) m_x = (m_x - P_STEP < P_XMIN) ? P_XMIN : m_x - P_STEP;
        if (mobile && r && !l) m_x = (m_x + P_STEP > P_XMAX) ? P_XMAX : m_x + P_STEP;
        eff = (m_cool > 0) ? m_cool - 1 : 0;
        m_fire = (f && mobile && eff == 0) ? 1 : 0;
        m_cool = m_fire ? P_COOL : eff;
        m_prevj = j;
    endtask

    task automatic check_all(input string ctx);
        int exp_pose;
        exp_pose = (m_st == S_SQ) ? 1 : (m_st == S_SH) ? 2 : 0;
        check({ctx, ".x"},    int'(o_x),        m_x);
        check({ctx, ".h"},    int'(o_h),        m_h);
        check({ctx, ".pose"}, int'(o_pose),     exp_pose);
        check({ctx, ".air"},  int'(o_airborne), (m_st == S_JMP) ? 1 : 0);
        check({ctx, ".fire"}, int'(o_fire),     m_fire);
    endtask

    task automatic do_tick(input string ctx, input bit l, r, j, sq, sh, f);
        @(negedge i_clk);
        {i_left, i_right, i_jump, i_squat, i_shield, i_fire} = {l, r, j, sq, sh, f};
        i_frame_tick = 1'b1;
        @(posedge i_clk);
        #1;
        i_frame_tick = 1'b0;
        model_tick(l, r, j, sq, sh, f);
        check_all(ctx);
    endtask

    task automatic idle(input string ctx, input int n);
        repeat (n) begin
            @(negedge i_clk);
            {i_left, i_right, i_jump, i_squat, i_shield, i_fire} = $urandom();
            @(posedge i_clk);
            #1;
            m_fire = 0;
            check_all(ctx);
        end
    endtask

    task automatic hard_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_active = 1'b1;
    endtask

    initial begin
        int jump_h [9] = '{20, 35, 45, 50, 50, 45, 35, 20, 0};
        int fires;

        model_reset();
        #12;
        check_all("reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_active = 1'b1;

        for (int t = 0; t < 5; t++) do_tick("idle", 0, 0, 0, 0, 0, 0);
        check("idle_x", int'(o_x), 120);

        // Single jump then idle: the trajectory is fixed by the physics constants.
        do_tick("jump1", 0, 0, 1, 0, 0, 0);
        check("jump_h0", int'(o_h), jump_h[0]);
        for (int t = 1; t < 9; t++) begin
            do_tick("jump1", 0, 0, 0, 0, 0, 0);
            check($sformatf("jump_h%0d", t), int'(o_h), jump_h[t]);
            check($sformatf("jump_air%0d", t), int'(o_airborne), (t < 8) ? 1 : 0);
        end
        idle("gap", 3);

        // Jump held across landing: landing tick does not re-launch, the next does.
        for (int t = 0; t < 9; t++) do_tick("jump_held", 0, 0, 1, 0, 0, 0);
        check("held_land_h", int'(o_h), 0);
        check("held_land_air", int'(o_airborne), 0);
        do_tick("jump_held", 0, 0, 1, 0, 0, 0);
        check("rejump_h", int'(o_h), 20);
        for (int t = 0; t < 8; t++) do_tick("land", 0, 0, 0, 0, 0, 0);

        // Horizontal boundaries.
        for (int t = 0; t < 22; t++) do_tick("left", 1, 0, 0, 0, 0, 0);
        check("left_clamp", int'(o_x), 0);
        for (int t = 0; t < 82; t++) do_tick("right", 0, 1, 0, 0, 0, 0);
        check("right_clamp", int'(o_x), 480);
        for (int t = 0; t < 3; t++) do_tick("left", 1, 0, 0, 0, 0, 0);
        check("left_step", int'(o_x), 462);
        do_tick("both", 1, 1, 0, 0, 0, 0);
        check("both_x", int'(o_x), 462);

        // Priorities.
        do_tick("sq_jump", 0, 0, 1, 1, 0, 0);
        check("sq_jump_pose", int'(o_pose), 0);
        check("sq_jump_air", int'(o_airborne), 1);
        do_tick("air_shield", 0, 0, 0, 0, 1, 0);
        check("air_shield_pose", int'(o_pose), 0);
        for (int t = 0; t < 8; t++) do_tick("land", 0, 0, 0, 0, 0, 0);
        do_tick("sq_right", 0, 1, 0, 1, 0, 0);
        check("sq_right_pose", int'(o_pose), 1);
        check("sq_right_x", int'(o_x), 462);

        // Held fire: pulses on ticks 1, 9, 17.
        hard_reset();
        check_all("post_reset");
        fires = 0;
        for (int t = 1; t <= 20; t++) begin
            do_tick("fire_held", 0, 0, 0, 0, 0, 1);
            check($sformatf("fire_t%0d", t), int'(o_fire), (t == 1 || t == 9 || t == 17) ? 1 : 0);
            fires += int'(o_fire);
            idle("fire_gap", 1);
        end
        check("fire_count", fires, 3);

        hard_reset();
        fires = 0;
        for (int t = 0; t < 12; t++) begin
            do_tick("shield_fire", 0, 0, 0, 0, 1, 1);
            fires += int'(o_fire);
        end
        check("shield_no_fire", fires, 0);

        // Asynchronous reset mid-jump and mid-cooldown.
        hard_reset();
        do_tick("pre_rst", 0, 0, 0, 0, 0, 1);
        do_tick("pre_rst", 0, 0, 1, 0, 0, 0);
        do_tick("pre_rst", 0, 0, 0, 0, 0, 0);
        do_tick("pre_rst", 0, 0, 0, 0, 0, 0);
        check("pre_rst_h", int'(o_h), 45);
        #3;
        i_rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst_h", int'(o_h), 0);
        check("async_rst_x", int'(o_x), 120);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Randomized phase.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 99) < 3) begin
                @(negedge i_clk);
                i_active = 1'b0;
                i_frame_tick = $urandom_range(0, 1);
                {i_left, i_right, i_jump, i_squat, i_shield, i_fire} = $urandom();
                @(posedge i_clk);
                #1;
                model_reset();
                check_all("inactive");
                @(negedge i_clk);
                i_frame_tick = 1'b0;
                i_active = 1'b1;
            end else begin
                do_tick("rand",
                        $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 40,
                        $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15,
                        $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 50);
                idle("rand_gap", $urandom_range(0, 2));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
